// File: rtl/voting_pkg.sv
// voting_pkg
// Shared constants and types for the four-candidate voting machine.
//   NUM_CANDIDATES  number of candidate buttons/counters
//   VOTE_COUNT_W    width of one vote counter (equals the LED width)
//   vote_count_t    one vote counter value
//   LED_ACK/LED_OFF led patterns for the vote acknowledge
//   MODE_VOTE/MODE_RESULT encodings of the mode input
package voting_pkg;

    localparam int unsigned NUM_CANDIDATES = 4;
    localparam int unsigned VOTE_COUNT_W   = 8;

    typedef logic [VOTE_COUNT_W-1:0] vote_count_t;

    localparam logic [7:0] LED_ACK = 8'hFF;
    localparam logic [7:0] LED_OFF = 8'h00;

    localparam logic MODE_VOTE   = 1'b0;
    localparam logic MODE_RESULT = 1'b1;

endpackage : voting_pkg

// File: rtl/button_debounce.sv
// button_debounce
// Debounces one raw active-high push-button. The hold counter advances while
// the button is high, clears on any low cycle and stops at DEBOUNCE_CYCLES,
// so a continuous press yields exactly one single-cycle valid pulse.
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous active-low reset
//   btn_in      raw button level
//   valid_pulse one-cycle pulse, high in the cycle the count reaches
//               DEBOUNCE_CYCLES
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_in,
    output logic valid_pulse
);

    localparam int unsigned   CW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] TARGET = CW'(DEBOUNCE_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_q, pulse_d;

    always_comb begin
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (!btn_in) begin
            cnt_d = '0;
        end else if (cnt_q != TARGET) begin
            cnt_d   = cnt_q + 1'b1;
            // Pulse is registered with the counter, so it is high exactly
            // while the counter first sits at TARGET.
            pulse_d = (cnt_d == TARGET);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign valid_pulse = pulse_q;

endmodule : button_debounce

// File: rtl/voting_machine.sv
// voting_machine
// Four-candidate voting machine with a registered 8-bit LED display.
// Vote mode (mode=0): a debounced press, alone in its cycle and outside the
// acknowledge window, adds one (saturating) vote and lights led=FF for
// ACK_CYCLES cycles. Result mode (mode=1): led shows the count of the
// lowest-numbered held button.
// Optional build macro VOTE_TOTAL_DISPLAY_EN: in result mode with no button
// held, led shows the saturated sum of all counts instead of 00.
// Ports:
//   clock   system clock, rising edge
//   reset   asynchronous active-low reset
//   mode    0 = vote, 1 = result
//   button1..button4  raw active-high candidate buttons
//   led     registered display output
module voting_machine
    import voting_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 10,
    parameter int unsigned ACK_CYCLES      = 10,
    parameter int unsigned COUNT_W         = VOTE_COUNT_W
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mode,
    input  logic       button1,
    input  logic       button2,
    input  logic       button3,
    input  logic       button4,
    output logic [7:0] led
);

    localparam int unsigned   TW       = $clog2(ACK_CYCLES + 1);
    localparam logic [TW-1:0] ACK_LOAD = TW'(ACK_CYCLES);

    logic [NUM_CANDIDATES-1:0] raw_btn;
    logic [NUM_CANDIDATES-1:0] pulse;

    logic [NUM_CANDIDATES-1:0][COUNT_W-1:0] cnt_q, cnt_d;
    logic [TW-1:0]                          timer_q, timer_d;
    logic [7:0]                             led_q, led_d;

    logic        single_pulse;
    logic        accept;
    vote_count_t sel_cnt;

    assign raw_btn = {button4, button3, button2, button1};

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1 (
        .clock(clock), .reset(reset), .btn_in(button1), .valid_pulse(pulse[0])
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db2 (
        .clock(clock), .reset(reset), .btn_in(button2), .valid_pulse(pulse[1])
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db3 (
        .clock(clock), .reset(reset), .btn_in(button3), .valid_pulse(pulse[2])
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db4 (
        .clock(clock), .reset(reset), .btn_in(button4), .valid_pulse(pulse[3])
    );

`ifdef VOTE_TOTAL_DISPLAY_EN
    // Two spare bits hold the sum of four counts without overflow.
    logic [COUNT_W+1:0] total;

    always_comb begin
        total = '0;
        for (int unsigned i = 0; i < NUM_CANDIDATES; i++) begin
            total = total + (COUNT_W+2)'(cnt_q[i]);
        end
    end
`endif

    // Exactly one pulse: non-zero and a power of two.
    assign single_pulse = (pulse != '0) && ((pulse & (pulse - 1'b1)) == '0);
    assign accept       = (mode == MODE_VOTE) && single_pulse && (timer_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        for (int unsigned i = 0; i < NUM_CANDIDATES; i++) begin
            // At full scale the vote is still acknowledged, just not counted.
            if (accept && pulse[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        timer_d = timer_q;
        if (mode == MODE_RESULT) begin
            timer_d = '0;
        end else if (accept) begin
            timer_d = ACK_LOAD;
        end else if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
        end
    end

    always_comb begin
        sel_cnt = '0;
        for (int i = NUM_CANDIDATES - 1; i >= 0; i--) begin
            // Descending scan so the lowest-numbered held button wins.
            if (raw_btn[i]) begin
                sel_cnt = cnt_q[i];
            end
        end
    end

    always_comb begin
        led_d = LED_OFF;
        if (mode == MODE_VOTE) begin
            led_d = (timer_q != '0) ? LED_ACK : LED_OFF;
        end else if (raw_btn != '0) begin
            led_d = sel_cnt;
        end else begin
`ifdef VOTE_TOTAL_DISPLAY_EN
            led_d = (total > (COUNT_W+2)'(8'hFF)) ? 8'hFF : total[7:0];
`else
            led_d = LED_OFF;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            timer_q <= '0;
            led_q   <= LED_OFF;
        end else begin
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            led_q   <= led_d;
        end
    end

    assign led = led_q;

endmodule : voting_machine

// File: tb/tb_voting_machine.sv
// tb_voting_machine
// Directed self-checking bench for voting_machine with default parameters
// (DEBOUNCE_CYCLES=10, ACK_CYCLES=10). Inputs change and outputs are sampled
// 1 time unit after each rising clock edge.
module tb_voting_machine;

    logic       clock;
    logic       reset;
    logic       mode;
    logic       button1, button2, button3, button4;
    logic [7:0] led;

    int unsigned checks;
    int unsigned errors;

    voting_machine #(
        .DEBOUNCE_CYCLES(10),
        .ACK_CYCLES     (10),
        .COUNT_W        (8)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .mode   (mode),
        .button1(button1),
        .button2(button2),
        .button3(button3),
        .button4(button4),
        .led    (led)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_buttons(input logic [3:0] b);
        button1 = b[0];
        button2 = b[1];
        button3 = b[2];
        button4 = b[3];
    endtask

    task automatic check_led(input string tag, input logic [7:0] exp);
        checks++;
        assert (led === exp) else begin
            errors++;
            $error("FAIL %s: led=%h expected=%h", tag, led, exp);
        end
    endtask

    // Result-mode read: hold buttons for one cycle, compare, return to vote mode.
    task automatic read_led(input string tag, input logic [3:0] b, input logic [7:0] exp);
        mode = 1'b1;
        set_buttons(b);
        tick(1);
        check_led(tag, exp);
        set_buttons(4'b0000);
        mode = 1'b0;
        tick(1);
    endtask

    // Hold buttons 20 cycles in vote mode. Pulse lands after edge 10, the vote
    // is accepted at edge 11, led is FF after edge 12 and 00 after edge 22.
    task automatic press(input string tag, input logic [3:0] b,
                         input bit do_check, input logic [7:0] exp_ack);
        mode = 1'b0;
        set_buttons(b);
        tick(12);
        if (do_check) check_led({tag, "_ack"}, exp_ack);
        tick(8);
        set_buttons(4'b0000);
        tick(2);
        if (do_check) check_led({tag, "_end"}, 8'h00);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        mode   = 1'b0;
        set_buttons(4'b0000);

        // 1: reset
        tick(1);
        check_led("reset_led", 8'h00);
        tick(19);
        reset = 1'b1;
        tick(1);
        check_led("post_reset_led", 8'h00);
        read_led("rst_c1", 4'b0001, 8'h00);
        read_led("rst_c2", 4'b0010, 8'h00);
        read_led("rst_c3", 4'b0100, 8'h00);
        read_led("rst_c4", 4'b1000, 8'h00);

        // 2: glitches then a real press on button1
        repeat (2) begin
            button1 = 1'b1;
            tick(1);
            button1 = 1'b0;
            tick(1);
        end
        tick(12);
        check_led("glitch_no_ack", 8'h00);
        button1 = 1'b1;
        tick(11);
        check_led("ack_latency", 8'h00);
        tick(1);
        check_led("ack_first", 8'hFF);
        tick(8);
        button1 = 1'b0;
        tick(1);
        check_led("ack_last", 8'hFF);
        tick(1);
        check_led("ack_over", 8'h00);
        read_led("t2_c1", 4'b0001, 8'h01);

        // 3: button2
        press("t3_b2", 4'b0010, 1'b1, 8'hFF);
        read_led("t3_c2", 4'b0010, 8'h01);

        // 4: simultaneous button2 + button3
        press("t4_dual", 4'b0110, 1'b1, 8'h00);
        read_led("t4_c2", 4'b0010, 8'h01);
        read_led("t4_c3", 4'b0100, 8'h00);

        // 5: result mode hold, pulse discarded, then button3 vote
        mode = 1'b1;
        button2 = 1'b1;
        tick(1);
        check_led("t5_res_c2", 8'h01);
        tick(12);
        check_led("t5_res_hold", 8'h01);
        button2 = 1'b0;
        mode = 1'b0;
        tick(1);
        check_led("t5_back_vote", 8'h00);
        read_led("t5_c2_unchanged", 4'b0010, 8'h01);
        press("t5_b3", 4'b0100, 1'b1, 8'hFF);
        read_led("t5_c3", 4'b0100, 8'h01);
`ifdef VOTE_TOTAL_DISPLAY_EN
        read_led("no_button", 4'b0000, 8'h03);
`else
        read_led("no_button", 4'b0000, 8'h00);
`endif

        // 6a: second press inside acknowledge window is discarded
        mode = 1'b0;
        button1 = 1'b1;
        tick(3);
        button2 = 1'b1;
        tick(9);
        check_led("win_ack", 8'hFF);
        tick(14);
        set_buttons(4'b0000);
        tick(2);
        check_led("win_end", 8'h00);
        read_led("win_c1", 4'b0001, 8'h02);
        read_led("win_c2", 4'b0010, 8'h01);
        read_led("prio_1_over_3", 4'b0101, 8'h02);
        read_led("prio_3_over_4", 4'b1100, 8'h01);

        // 6b: saturation of candidate 4
        for (int i = 0; i < 255; i++) press("sat", 4'b1000, 1'b0, 8'h00);
        read_led("sat_255", 4'b1000, 8'hFF);
        press("sat_256", 4'b1000, 1'b1, 8'hFF);
        read_led("sat_hold", 4'b1000, 8'hFF);
        read_led("sat_prio", 4'b1010, 8'h01);

        // 6c: asynchronous reset mid-acknowledge, press held through release
        mode = 1'b0;
        button3 = 1'b1;
        tick(12);
        check_led("pre_reset_ack", 8'hFF);
        button3 = 1'b0;
        button1 = 1'b1;
        reset = 1'b0;
        #1;
        check_led("async_reset", 8'h00);
        tick(2);
        reset = 1'b1;
        tick(11);
        check_led("redebounce_wait", 8'h00);
        tick(1);
        check_led("redebounce_ack", 8'hFF);
        button1 = 1'b0;
        tick(12);
        read_led("rr_c1", 4'b0001, 8'h01);
        read_led("rr_c3", 4'b0100, 8'h00);
        read_led("rr_c4", 4'b1000, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_voting_machine

// File: doc/voting_machine.md
Name: voting_machine

Overview:
- Four-candidate electronic voting machine with one 8-bit LED output.
- Each of the four push-buttons is debounced. In vote mode, an accepted press adds one vote to that candidate's counter and gives a visible acknowledge on the LEDs.
- In result mode, holding a candidate's button shows that candidate's vote count on the LEDs.
- Top-level leaf block of the kiosk design. It sits directly behind the board's button and LED pins.

Parameters:
- DEBOUNCE_CYCLES, 10: consecutive high cycles a button must be held before a press is valid.
- ACK_CYCLES, 10: number of cycles the vote acknowledge is shown on led.
- COUNT_W, 8: width of each vote counter. Must equal the led width of 8.

Ports:
- clock input 1: single system clock; all state updates on the rising edge.
- reset input 1: asynchronous, active-low reset. Assertion clears all state immediately; deassertion is synchronous to clock.
- mode input 1: 0 = vote mode, 1 = result mode. Sampled every clock.
- button1 input 1: candidate 1 push-button, active-high, raw (not debounced).
- button2 input 1: candidate 2 push-button, same as button1.
- button3 input 1: candidate 3 push-button, same as button1.
- button4 input 1: candidate 4 push-button, same as button1.
- led output 8: registered display output.

Behaviour:
- Reset (reset=0):
  - led = 8'h00.
  - All four vote counters = 0.
  - Debounce counters = 0.
  - Acknowledge timer = 0.
- Debounce, per button:
  - The counter increments while the button is 1 and clears to 0 on any cycle the button is 0.
  - A one-cycle valid pulse is issued on the cycle the counter reaches DEBOUNCE_CYCLES.
  - The counter then holds, so there is at most one pulse per continuous press.
  - Presses shorter than DEBOUNCE_CYCLES produce nothing.
- Vote acceptance, mode=0 only:
  - A vote is accepted only when exactly one valid pulse occurs in a cycle and the acknowledge timer is 0.
  - On acceptance, that candidate's counter increments on the same edge.
  - Counters saturate at 255; at 255 the vote is still acknowledged but not counted.
  - Two or more valid pulses in the same cycle: no vote counted, no acknowledge.
  - Valid pulses while the acknowledge timer is non-zero are discarded.
  - Valid pulses while mode=1 are discarded.
- Acknowledge, mode=0:
  - An accepted vote loads the timer with ACK_CYCLES.
  - led = 8'hFF while the timer is non-zero; the timer decrements each cycle.
  - led = 8'h00 otherwise.
  - led goes to FF one cycle after the accepting edge, because led is registered.
- Result display, mode=1:
  - led = count of the lowest-numbered candidate whose raw button is currently 1 (priority button1 > button2 > button3 > button4).
  - Shown with one cycle of latency.
  - No button held: led = 8'h00, unless the optional feature is enabled.
- Mode switching:
  - Entering mode 1 clears the acknowledge timer immediately.
  - Returning to mode 0 shows led = 00 until the next accepted vote.
  - Counts persist across mode changes; only reset clears them.
- Reset mid-operation: counts, timers and led clear asynchronously. A press held through reset release must again be held for DEBOUNCE_CYCLES before it counts.

Optional Feature:
- Macro: VOTE_TOTAL_DISPLAY_EN.
- Defined: in mode 1 with no button held, led = sum of all four counts, saturated at 255.
- Undefined: led = 8'h00 in that case.
- Vote counting is identical either way.

Decomposition:
- Package voting_pkg holds:
  - NUM_CANDIDATES = 4.
  - LED_ACK = 8'hFF and LED_OFF = 8'h00.
  - MODE_VOTE = 1'b0 and MODE_RESULT = 1'b1.
  - A count typedef of width COUNT_W.
- Sub-module button_debounce is instantiated four times. Ports: clock, reset, btn_in, valid_pulse; parameter DEBOUNCE_CYCLES.
- Counters, acceptance logic and the led mux stay in voting_machine.

Test Plan:
1. Reset low for 20 cycles with all inputs 0, then release: led=00; result-mode reads of all candidates = 00.
2. Mode 0, button1 glitches high for 1 cycle twice, then held 20 cycles:
   - Exactly one vote is counted.
   - led=FF for 10 cycles, then 00.
   - Result mode with button1 shows 01.
3. Mode 0, button2 held 20 cycles, then released: candidate 2 count = 1, with the acknowledge pulse.
4. Mode 0, button2 and button3 rise on the same cycle, held 20 cycles: no acknowledge; counts for candidates 2 and 3 unchanged (1 and 0).
5. Mode 1, button2 held: led=01 after one cycle; no vote added. Then button3 held in mode 0 for 20 cycles: candidate 3 count = 1, and result mode shows 01.
6. Boundary cases:
   - 256 accepted votes for candidate 4 leave its count at FF.
   - A second valid press arriving inside the 10-cycle acknowledge window is discarded.
   - Asserting reset mid-acknowledge drops led to 00 immediately.
